// File: rtl/k12a_clock_pkg.sv
// Shared types and helpers for the K12A CPU clock sequencer.
package k12a_clock_pkg;

    typedef enum logic [1:0] {
        CLK_HALTED = 2'd0,
        CLK_RUN    = 2'd1,
        CLK_STEP   = 2'd2
    } clk_state_t;

    // Width of the wait-state down-counter; never narrower than one bit.
    function automatic int wait_w(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/k12a_clock_seq.sv
// K12A CPU clock sequencer: cpu_clock generation, run/halt/step control, wait-state stretching.
// Optional cycle counter enabled by defining K12A_CYCLE_COUNTER_EN.
module k12a_clock_seq
    import k12a_clock_pkg::*;
#(
    parameter int WAIT_STATES   = 2,
    parameter bit START_RUNNING = 1'b1
) (
    input  logic        sys_clock,
    input  logic        reset_n,
    input  logic        run_req,
    input  logic        halt_req,
    input  logic        step_req,
    input  logic        wait_req,
    output logic        cpu_clock,
    output logic        async_write,
    output logic        halted,
    output logic        step_done,
    output logic [31:0] cycle_count
);

    localparam int              WW      = wait_w(WAIT_STATES);
    localparam logic [WW-1:0]   WS_INIT = WW'(WAIT_STATES);
    localparam clk_state_t      RST_ST  = START_RUNNING ? CLK_RUN : CLK_HALTED;

    clk_state_t    state;
    logic [WW-1:0] wait_cnt;
    logic          write_en;
    logic          in_cycle;   // a high phase has been issued since leaving HALTED
    logic          halt_pend;  // halt seen during RUN, honoured at the next boundary
    logic          cycle_done;

    assign cycle_done  = (state != CLK_HALTED) && in_cycle && !cpu_clock && (wait_cnt == '0);
    assign async_write = sys_clock & ~cpu_clock & write_en;
    assign halted      = (state == CLK_HALTED);

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RST_ST;
            cpu_clock <= 1'b0;
            write_en  <= 1'b0;
            wait_cnt  <= '0;
            step_done <= 1'b0;
            in_cycle  <= 1'b0;
            halt_pend <= 1'b0;
        end else begin
            step_done <= 1'b0;
            case (state)
                CLK_HALTED: begin
                    cpu_clock <= 1'b0;
                    write_en  <= 1'b0;
                    wait_cnt  <= '0;
                    in_cycle  <= 1'b0;
                    halt_pend <= 1'b0;
                    if (!halt_req) begin
                        if (run_req)
                            state <= CLK_RUN;
                        else if (step_req)
                            state <= CLK_STEP;
                    end
                end
                CLK_RUN, CLK_STEP: begin
                    if (state == CLK_RUN && halt_req)
                        halt_pend <= 1'b1;
                    if (!in_cycle) begin
                        // first edge after entry always opens a full high phase
                        cpu_clock <= 1'b1;
                        in_cycle  <= 1'b1;
                    end else if (cpu_clock) begin
                        cpu_clock <= 1'b0;
                        if (wait_req && (WAIT_STATES > 0)) begin
                            wait_cnt <= WS_INIT;
                            write_en <= 1'b0;
                        end else begin
                            write_en <= 1'b1;
                        end
                    end else if (!cycle_done) begin
                        wait_cnt <= wait_cnt - WW'(1);
                        write_en <= (wait_cnt == WW'(1));
                    end else begin
                        write_en <= 1'b0;
                        if (state == CLK_STEP) begin
                            state     <= CLK_HALTED;
                            step_done <= 1'b1;
                            in_cycle  <= 1'b0;
                        end else if (halt_req || halt_pend) begin
                            state     <= CLK_HALTED;
                            in_cycle  <= 1'b0;
                            halt_pend <= 1'b0;
                        end else begin
                            cpu_clock <= 1'b1;
                        end
                    end
                end
                default: state <= CLK_HALTED;
            endcase
        end
    end

`ifdef K12A_CYCLE_COUNTER_EN
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n)
            cycle_count <= 32'h0;
        else if (cycle_done)
            cycle_count <= cycle_count + 32'd1;
    end
`else
    assign cycle_count = 32'h0;
`endif

endmodule

// File: tb/tb_k12a_clock_seq.sv
// Directed self-checking bench for k12a_clock_seq (WAIT_STATES=2, START_RUNNING=1).
module tb_k12a_clock_seq;

    logic        sys_clock = 1'b0;
    logic        reset_n;
    logic        run_req, halt_req, step_req, wait_req;
    logic        cpu_clock, async_write, halted, step_done;
    logic [31:0] cycle_count;

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc   = 0;
    int acc;

    k12a_clock_seq #(.WAIT_STATES(2), .START_RUNNING(1'b1)) dut (
        .sys_clock   (sys_clock),
        .reset_n     (reset_n),
        .run_req     (run_req),
        .halt_req    (halt_req),
        .step_req    (step_req),
        .wait_req    (wait_req),
        .cpu_clock   (cpu_clock),
        .async_write (async_write),
        .halted      (halted),
        .step_done   (step_done),
        .cycle_count (cycle_count)
    );

    always #5 sys_clock = ~sys_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // sample 1 time unit after the active edge, while sys_clock is high
    task automatic tick();
        @(posedge sys_clock);
        #1;
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef K12A_CYCLE_COUNTER_EN
        return 32'(n);
`else
        return 32'h0;
`endif
    endfunction

    initial begin
        reset_n = 1'b0; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0; wait_req = 1'b0;
        repeat (3) tick();
        check("rst_cpu", {31'b0, cpu_clock}, 32'd0);
        check("rst_aw", {31'b0, async_write}, 32'd0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        check("rst_step_done", {31'b0, step_done}, 32'd0);
        check("rst_count", cycle_count, 32'd0);
        @(negedge sys_clock) reset_n = 1'b1;

        // 1: free run, plain divide-by-2
        tick();
        check("t1_first_high", {31'b0, cpu_clock}, 32'd1);
        check("t1_first_aw", {31'b0, async_write}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t1_cpu", {31'b0, cpu_clock}, (i % 2 == 0) ? 32'd0 : 32'd1);
            check("t1_aw", {31'b0, async_write}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        n_cyc = 3;
        check("t1_count", cycle_count, exp_cnt(n_cyc));

        // 2: wait_req at the high->low edge stretches low phase to 3 cycles
        wait_req = 1'b1;
        tick();
        wait_req = 1'b0;
        check("t2_low1_cpu", {31'b0, cpu_clock}, 32'd0);
        check("t2_low1_aw", {31'b0, async_write}, 32'd0);
        check("t2_wait_cnt", {30'b0, dut.wait_cnt}, 32'd2);
        tick();
        check("t2_low2_cpu", {31'b0, cpu_clock}, 32'd0);
        check("t2_low2_aw", {31'b0, async_write}, 32'd0);
        tick();
        check("t2_low3_cpu", {31'b0, cpu_clock}, 32'd0);
        check("t2_low3_aw", {31'b0, async_write}, 32'd1);
        tick();
        n_cyc++;
        check("t2_high_cpu", {31'b0, cpu_clock}, 32'd1);
        check("t2_high_aw", {31'b0, async_write}, 32'd0);
        // wait_req raised only during the low phase is ignored
        tick();
        wait_req = 1'b1;
        tick();
        wait_req = 1'b0;
        n_cyc++;
        check("t2_ignore_cpu", {31'b0, cpu_clock}, 32'd1);
        check("t2_count", cycle_count, exp_cnt(n_cyc));

        // 3: halt_req pulse in the high phase, cycle completes then halts
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("t3_low_cpu", {31'b0, cpu_clock}, 32'd0);
        check("t3_low_aw", {31'b0, async_write}, 32'd1);
        check("t3_not_yet", {31'b0, halted}, 32'd0);
        tick();
        n_cyc++;
        check("t3_halted", {31'b0, halted}, 32'd1);
        check("t3_cpu0", {31'b0, cpu_clock}, 32'd0);
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            acc += int'(cpu_clock) + int'(async_write);
        end
        check("t3_stay_low", 32'(acc), 32'd0);
        check("t3_still_halted", {31'b0, halted}, 32'd1);
        check("t3_count", cycle_count, exp_cnt(n_cyc));

        // 4: single step
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        check("t4_enter_step", {31'b0, halted}, 32'd0);
        check("t4_enter_cpu", {31'b0, cpu_clock}, 32'd0);
        tick();
        check("t4_high", {31'b0, cpu_clock}, 32'd1);
        tick();
        check("t4_low", {31'b0, cpu_clock}, 32'd0);
        check("t4_low_aw", {31'b0, async_write}, 32'd1);
        check("t4_sd_early", {31'b0, step_done}, 32'd0);
        tick();
        n_cyc++;
        check("t4_step_done", {31'b0, step_done}, 32'd1);
        check("t4_halted", {31'b0, halted}, 32'd1);
        check("t4_cpu_end", {31'b0, cpu_clock}, 32'd0);
        check("t4_count", cycle_count, exp_cnt(n_cyc));
        tick();
        check("t4_sd_clear", {31'b0, step_done}, 32'd0);
        check("t4_cpu_stays", {31'b0, cpu_clock}, 32'd0);

        // 5: run_req and step_req together pick RUN
        run_req = 1'b1; step_req = 1'b1;
        tick();
        run_req = 1'b0; step_req = 1'b0;
        check("t5_left_halt", {31'b0, halted}, 32'd0);
        acc = 0;
        tick();
        acc += int'(step_done);
        check("t5_high", {31'b0, cpu_clock}, 32'd1);
        tick();
        acc += int'(step_done);
        check("t5_low", {31'b0, cpu_clock}, 32'd0);
        tick();
        acc += int'(step_done);
        n_cyc++;
        check("t5_high2", {31'b0, cpu_clock}, 32'd1);
        check("t5_no_step_done", 32'(acc), 32'd0);
        check("t5_running", {31'b0, halted}, 32'd0);
        check("t5_count", cycle_count, exp_cnt(n_cyc));

        // 6: reset during a wait stretch
        wait_req = 1'b1;
        tick();
        wait_req = 1'b0;
        check("t6_stretch", {30'b0, dut.wait_cnt}, 32'd2);
        reset_n = 1'b0;
        #1;
        check("t6_cpu", {31'b0, cpu_clock}, 32'd0);
        check("t6_aw", {31'b0, async_write}, 32'd0);
        check("t6_wait_cnt", {30'b0, dut.wait_cnt}, 32'd0);
        check("t6_count", cycle_count, 32'd0);
        tick();
        @(negedge sys_clock) reset_n = 1'b1;
        check("t6_run_state", {31'b0, halted}, 32'd0);
        tick();
        check("t6_restart", {31'b0, cpu_clock}, 32'd1);
        check("t6_count_after", cycle_count, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
